// File: rtl/vdp_pkg.sv
// Shared draw-domain types and sizes for the video pipeline.
// Consumed by the line fetcher and the pixel alignment helpers.
package vdp_pkg;
  localparam int PIX_W       = 8;
  localparam int LANES       = 16;
  localparam int LINE_WORD_W = PIX_W * LANES;
  localparam int LB_ADDRW    = 7;
  localparam int LINE_WORDS  = 80;

  typedef logic [LINE_WORD_W-1:0] line_word_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fsm_state_e;
endpackage

// File: rtl/fine_shift.sv
// Combinational 256->128 funnel shifter in whole-pixel steps.
// word_o pixel i = pixel (i + sh_i) of the concatenation {hi_i, lo_i}.
module fine_shift
  import vdp_pkg::*;
(
  input  line_word_t lo_i,
  input  line_word_t hi_i,
  input  logic [3:0] sh_i,
  output line_word_t word_o
);
  logic [2*LINE_WORD_W-1:0] cat;

  assign cat = {hi_i, lo_i};
  // Shift amount in bits is sh_i * 8; the top pixel index 15+15 stays inside cat.
  assign word_o = cat[{sh_i, 3'b000} +: LINE_WORD_W];
endmodule

// File: rtl/line_fetch.sv
// Fills the off-screen scanline buffer: fetches WORDS+1 source words, applies
// the horizontal fine scroll and writes WORDS aligned 16-pixel words.
module line_fetch
  import vdp_pkg::*;
#(
  parameter int WORDS = LINE_WORDS,
  parameter int ADDRW = LB_ADDRW,
  parameter int MEMAW = 20
) (
  input  logic             clk_draw,
  input  logic             rst_draw_n,
  input  logic             start,
  input  logic [MEMAW-1:0] line_base,
  input  logic [3:0]       fine_x,
  output logic             busy,
  output logic             done,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [MEMAW-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  line_word_t       mem_rsp_data,
  output logic [ADDRW-1:0] lb_addr_off,
  output logic [LANES-1:0] lb_we_off,
  output line_word_t       lb_colour_off
);
  localparam int JW = $clog2(WORDS + 1);

  fsm_state_e       state_q, state_d;
  logic [MEMAW-1:0] base_q, base_d;
  logic [3:0]       fine_q, fine_d;
  logic [JW-1:0]    j_q, j_d;
  line_word_t       cur_q, cur_d;
  logic             got_q, got_d;
  line_word_t       prev_q, prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_valid_q, req_valid_d;
  logic [MEMAW-1:0] req_addr_q, req_addr_d;
  logic [ADDRW-1:0] lb_addr_q, lb_addr_d;
  logic [LANES-1:0] lb_we_q, lb_we_d;
  line_word_t       lb_colour_q, lb_colour_d;
  line_word_t       shifted;

  fine_shift u_shift (
    .lo_i  (prev_q),
    .hi_i  (cur_q),
    .sh_i  (fine_q),
    .word_o(shifted)
  );

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      fine_q      <= '0;
      j_q         <= '0;
      cur_q       <= '0;
      got_q       <= 1'b0;
      prev_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      lb_addr_q   <= '0;
      lb_we_q     <= '0;
      lb_colour_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      fine_q      <= fine_d;
      j_q         <= j_d;
      cur_q       <= cur_d;
      got_q       <= got_d;
      prev_q      <= prev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      lb_addr_q   <= lb_addr_d;
      lb_we_q     <= lb_we_d;
      lb_colour_q <= lb_colour_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    fine_d      = fine_q;
    j_d         = j_q;
    cur_d       = cur_q;
    got_d       = got_q;
    prev_d      = prev_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    lb_addr_d   = lb_addr_q;
    lb_we_d     = '0;
    lb_colour_d = lb_colour_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d      = line_base;
        fine_d      = fine_x;
        j_d         = '0;
        prev_d      = '0;
        got_d       = 1'b0;
        busy_d      = 1'b1;
        req_valid_d = 1'b1;
        req_addr_d  = line_base;
        state_d     = REQ;
      end
      REQ: if (mem_req_ready) begin
        req_valid_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        // First cycle captures the response, second emits the aligned word.
        if (!got_q) begin
          if (mem_rsp_valid) begin
            cur_d = mem_rsp_data;
            got_d = 1'b1;
          end
        end else begin
          got_d  = 1'b0;
          prev_d = cur_q;
          if (j_q != '0) begin
            lb_addr_d   = ADDRW'(j_q - 1'b1);
            lb_we_d     = '1;
            lb_colour_d = shifted;
          end
          if (j_q == JW'(WORDS)) begin
            state_d = DONE;
          end else begin
            j_d         = j_q + 1'b1;
            req_valid_d = 1'b1;
            req_addr_d  = base_q + MEMAW'(j_d);
            state_d     = REQ;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign lb_addr_off   = lb_addr_q;
  assign lb_we_off     = lb_we_q;
  assign lb_colour_off = lb_colour_q;
endmodule

// File: tb/tb_line_fetch.sv
// Scoreboard bench for line_fetch: a memory model answers requests, expected
// requests and line-buffer writes are queued at launch and popped as they appear.
module tb_line_fetch;
  import vdp_pkg::*;
  localparam int WORDS = 80;
  localparam int ADDRW = 7;
  localparam int MEMAW = 20;

  logic             clk_draw = 1'b0;
  logic             rst_draw_n = 1'b0;
  logic             start = 1'b0;
  logic [MEMAW-1:0] line_base = '0;
  logic [3:0]       fine_x = '0;
  logic             busy, done, mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [MEMAW-1:0] mem_req_addr;
  logic             mem_rsp_valid = 1'b0;
  line_word_t       mem_rsp_data = '0;
  logic [ADDRW-1:0] lb_addr_off;
  logic [15:0]      lb_we_off;
  line_word_t       lb_colour_off;

  int n_cmp = 0, n_err = 0;

  always #5 clk_draw = ~clk_draw;

  line_fetch #(.WORDS(WORDS), .ADDRW(ADDRW), .MEMAW(MEMAW)) dut (
    .clk_draw     (clk_draw),
    .rst_draw_n   (rst_draw_n),
    .start        (start),
    .line_base    (line_base),
    .fine_x       (fine_x),
    .busy         (busy),
    .done         (done),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .lb_addr_off  (lb_addr_off),
    .lb_we_off    (lb_we_off),
    .lb_colour_off(lb_colour_off)
  );

  typedef struct {
    logic [ADDRW-1:0] addr;
    line_word_t       col;
  } wr_t;

  wr_t              exp_wr[$];
  logic [MEMAW-1:0] exp_req[$];

  // Memory word n holds lanes {n[7:0]+15 .. n[7:0]+0}.
  function automatic line_word_t mem_word(input logic [MEMAW-1:0] a);
    line_word_t w;
    for (int l = 0; l < 16; l++) w[8*l +: 8] = a[7:0] + 8'(l);
    return w;
  endfunction

  function automatic line_word_t exp_word(input logic [MEMAW-1:0] base, input int k, input int fx);
    line_word_t w, a, b;
    int p;
    a = mem_word(base + MEMAW'(k));
    b = mem_word(base + MEMAW'(k + 1));
    for (int i = 0; i < 16; i++) begin
      p = i + fx;
      w[8*i +: 8] = (p < 16) ? a[8*p +: 8] : b[8*(p-16) +: 8];
    end
    return w;
  endfunction

  // Memory model: random stalls, fixed latency, checks single outstanding request.
  int               stall_max = 0, lat = 1;
  int               stall_cnt = 0, stall_tgt = 0, rsp_cnt = 0, req_cnt = 0;
  logic             was_stalled = 1'b0;
  logic [MEMAW-1:0] pend_addr = '0, last_addr = '0, e_req;

  always @(negedge clk_draw) begin
    if (!rst_draw_n) begin
      rsp_cnt = 0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
      was_stalled = 1'b0; stall_cnt = 0;
    end else begin
      mem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(pend_addr);
        end
      end
      if (was_stalled && mem_req_valid) begin
        n_cmp++;
        if (mem_req_addr !== last_addr) begin
          n_err++;
          $display("FAIL req_addr_stable got=%h exp=%h", mem_req_addr, last_addr);
        end
      end
      if (!mem_req_valid) begin
        was_stalled   = 1'b0;
        stall_cnt     = 0;
        stall_tgt     = (stall_max == 0) ? 0 : int'($urandom_range(1, stall_max));
        mem_req_ready = 1'($urandom_range(0, 1));
      end else if (stall_cnt < stall_tgt) begin
        mem_req_ready = 1'b0;
        stall_cnt++;
        was_stalled = 1'b1;
        last_addr   = mem_req_addr;
      end else begin
        mem_req_ready = 1'b1;
        was_stalled   = 1'b0;
        n_cmp++;
        if (rsp_cnt != 0 || mem_rsp_valid) begin
          n_err++;
          $display("FAIL outstanding got=%0d exp=0", rsp_cnt + int'(mem_rsp_valid));
        end
        n_cmp++;
        if (exp_req.size() == 0) begin
          n_err++;
          $display("FAIL req_addr got=%h exp=none", mem_req_addr);
        end else begin
          e_req = exp_req.pop_front();
          if (mem_req_addr !== e_req) begin
            n_err++;
            $display("FAIL req_addr got=%h exp=%h", mem_req_addr, e_req);
          end
        end
        pend_addr = mem_req_addr;
        rsp_cnt   = lat;
        req_cnt++;
      end
    end
  end

  // Line-buffer write monitor.
  int  wr_cnt = 0, done_cnt = 0;
  wr_t e_wr;

  always @(negedge clk_draw) begin
    if (rst_draw_n) begin
      if (done) done_cnt++;
      if (lb_we_off !== 16'h0) begin
        wr_cnt++;
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL lb_write got addr=%0d exp=none", lb_addr_off);
        end else begin
          e_wr = exp_wr.pop_front();
          if (lb_we_off !== 16'hffff || lb_addr_off !== e_wr.addr || lb_colour_off !== e_wr.col) begin
            n_err++;
            $display("FAIL lb_write got we=%h addr=%0d col=%h exp we=ffff addr=%0d col=%h",
                     lb_we_off, lb_addr_off, lb_colour_off, e_wr.addr, e_wr.col);
          end
        end
      end
    end
  end

  task automatic launch(input logic [MEMAW-1:0] base, input logic [3:0] fx);
    wr_t w;
    exp_wr.delete();
    exp_req.delete();
    for (int k = 0; k <= WORDS; k++) exp_req.push_back(base + MEMAW'(k));
    for (int k = 0; k < WORDS; k++) begin
      w.addr = ADDRW'(k);
      w.col  = exp_word(base, k, int'(fx));
      exp_wr.push_back(w);
    end
    @(negedge clk_draw);
    start = 1'b1; line_base = base; fine_x = fx;
    @(posedge clk_draw); #1;
    start = 1'b0;
  endtask

  // n = posedges since (and including) the start-sampling edge; -1 on timeout.
  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (!done && n < budget) begin
      @(posedge clk_draw); #1;
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    logic seen;
    repeat (3) @(posedge clk_draw);
    #1;
    n_cmp++;
    if ({busy, done, mem_req_valid, mem_req_addr, lb_addr_off, lb_we_off, lb_colour_off} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b vld=%b addr=%h lba=%h we=%h exp all 0",
               busy, done, mem_req_valid, mem_req_addr, lb_addr_off, lb_we_off);
    end
    @(negedge clk_draw); rst_draw_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_draw); #1;
      if (busy || done || mem_req_valid || mem_req_addr != '0 || lb_we_off != '0 ||
          lb_addr_off != '0 || lb_colour_off != '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet got activity=%b exp=0", seen);
    end
  endtask

  task automatic check_line(input string tag, input int n, input int exp_n, input int w0, input int r0, input int d0);
    if (exp_n > 0) begin
      n_cmp++;
      if (n !== exp_n) begin n_err++; $display("FAIL %s done_cycle got=%0d exp=%0d", tag, n, exp_n); end
    end else begin
      n_cmp++;
      if (n < 0) begin n_err++; $display("FAIL %s done_timeout got=%0d exp=done", tag, n); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done got=%b exp=0", tag, busy); end
    repeat (20) @(posedge clk_draw);
    #1;
    n_cmp++;
    if (wr_cnt - w0 !== WORDS) begin n_err++; $display("FAIL %s writes got=%0d exp=%0d", tag, wr_cnt - w0, WORDS); end
    n_cmp++;
    if (req_cnt - r0 !== WORDS + 1) begin n_err++; $display("FAIL %s requests got=%0d exp=%0d", tag, req_cnt - r0, WORDS + 1); end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL %s done_pulses got=%0d exp=1", tag, done_cnt - d0); end
    n_cmp++;
    if (exp_wr.size() != 0 || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL %s leftover got wr=%0d req=%0d exp 0/0", tag, exp_wr.size(), exp_req.size());
    end
  endtask

  task automatic test_plain();
    int n, w0 = wr_cnt, r0 = req_cnt, d0 = done_cnt;
    stall_max = 0; lat = 1;
    launch(20'h100, 4'd0);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL plain busy_after_start got=%b exp=1", busy); end
    wait_done(1, 1000, n);
    @(posedge clk_draw); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL plain done_width got=%b exp=0", done); end
    check_line("plain", n, 245, w0, r0, d0);
  endtask

  task automatic test_fine_scroll();
    int n, w0 = wr_cnt, r0 = req_cnt, d0 = done_cnt;
    stall_max = 0; lat = 1;
    launch(20'h100, 4'd5);
    wait_done(1, 1000, n);
    check_line("fine5", n, 245, w0, r0, d0);
  endtask

  task automatic test_stall();
    int n, w0 = wr_cnt, r0 = req_cnt, d0 = done_cnt;
    stall_max = 3; lat = 4;
    launch(20'h100, 4'd5);
    wait_done(1, 3000, n);
    check_line("stall", n, 0, w0, r0, d0);
    stall_max = 0; lat = 1;
  endtask

  task automatic test_restart_ignored();
    int n, w0 = wr_cnt, r0 = req_cnt, d0 = done_cnt;
    stall_max = 0; lat = 1;
    launch(20'h100, 4'd0);
    repeat (9) @(posedge clk_draw);
    @(negedge clk_draw);
    start = 1'b1; line_base = 20'h900; fine_x = 4'd9;
    @(posedge clk_draw); #1;
    start = 1'b0;
    wait_done(11, 1000, n);
    check_line("restart", n, 245, w0, r0, d0);
  endtask

  task automatic test_reset_midline();
    int n, w0 = wr_cnt, r0, d0 = done_cnt;
    stall_max = 0; lat = 1;
    launch(20'h100, 4'd3);
    n = 0;
    while (wr_cnt < w0 + 30 && n < 2000) begin @(posedge clk_draw); #1; n++; end
    n_cmp++;
    if (wr_cnt < w0 + 30) begin n_err++; $display("FAIL midline write30_timeout got=%0d exp=30", wr_cnt - w0); end
    #2 rst_draw_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_req_valid, mem_req_addr, lb_addr_off, lb_we_off, lb_colour_off} !== '0) begin
      n_err++;
      $display("FAIL midline async_reset got busy=%b vld=%b addr=%h lba=%h we=%h exp all 0",
               busy, mem_req_valid, mem_req_addr, lb_addr_off, lb_we_off);
    end
    exp_wr.delete();
    exp_req.delete();
    repeat (3) @(posedge clk_draw);
    @(negedge clk_draw); rst_draw_n = 1'b1;
    repeat (5) @(posedge clk_draw);
    #1;
    n_cmp++;
    if (done_cnt !== d0) begin n_err++; $display("FAIL midline done_on_abort got=%0d exp=%0d", done_cnt, d0); end
    w0 = wr_cnt; r0 = req_cnt; d0 = done_cnt;
    launch(20'hFFFFA, 4'd7);
    wait_done(1, 1000, n);
    check_line("wrap", n, 245, w0, r0, d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plain();
    test_fine_scroll();
    test_stall();
    test_restart_ignored();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
